uart_top: RTL and testbench

Board-level top of the simple-uart design for the Zybo Z7-20 (125 MHz sysclk). It holds one 8N1 UART transmitter and one 8N1 UART receiver, each enabled by its own push button. An RGB LED per direction shows whether that direction is enabled. The transmitter sends the switch value and the receiver shows the low nibble of each received byte on the four user LEDs.

---
 rtl/uart_top.sv | 201 ++++++++++++++++++++
 tb/tb_uart_top.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_top.sv
// Board top for the simple-uart design: one 8N1 transmitter sending the switch nibble and
// one 8N1 receiver showing the low nibble of each good byte, each enabled by a push button.
module uart_top #(
   parameter int unsigned CLKS_PER_BIT = 1085,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       sysclk,
   input  logic       rst_n,
   input  logic [1:0] btn,
   input  logic [3:0] sw,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic [3:0] led,
   output logic       led5_r,
   output logic       led5_g,
   output logic       led5_b,
   output logic       led6_r,
   output logic       led6_g,
   output logic       led6_b
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BaudW-1:0] BaudHalf =
      BaudW'((CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 - 1 : 0);
   // Synchronizer idle pattern {btn, sw, uart_rx}: buttons released, line high
   localparam logic [6:0] SyncIdle = 7'b000_0001;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [SYNC_STAGES-1:0][6:0] sync_q = {SYNC_STAGES{SyncIdle}};
   logic [1:0] btn_s;
   logic [3:0] sw_s;
   logic       rx_s;

   logic       tx_en_q = 1'b0, tx_en_prev_q = 1'b0, rx_en_q = 1'b0, rx_prev_q = 1'b1;
   logic [1:0] tx_rg_q = 2'b10, rx_rg_q = 2'b10;

   state_e            tx_state_q = StIdle, tx_state_d;
   logic [BaudW-1:0]  tx_baud_q = '0, tx_baud_d;
   logic [2:0]        tx_bit_q = '0, tx_bit_d;
   logic [7:0]        tx_data_q = '0, tx_data_d;
   logic [3:0]        tx_last_q = '0, tx_last_d;
   logic              uart_tx_q = 1'b1, uart_tx_d;
   logic              tx_bit_end;

   state_e            rx_state_q = StIdle, rx_state_d;
   logic [BaudW-1:0]  rx_baud_q = '0, rx_baud_d;
   logic [2:0]        rx_bit_q = '0, rx_bit_d;
   logic [7:0]        rx_data_q = '0, rx_data_d;
   logic [3:0]        led_q = '0, led_d;
   logic              rx_bit_end;

   assign btn_s = sync_q[SYNC_STAGES-1][6:5];
   assign sw_s  = sync_q[SYNC_STAGES-1][4:1];
   assign rx_s  = sync_q[SYNC_STAGES-1][0];

   always_comb begin
      tx_state_d = tx_state_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_data_d  = tx_data_q;
      tx_last_d  = tx_last_q;
      uart_tx_d  = uart_tx_q;
      tx_bit_end = (tx_baud_q == BaudLast);
      if (tx_state_q != StIdle) tx_baud_d = tx_bit_end ? '0 : tx_baud_q + 1'b1;
      unique case (tx_state_q)
         StIdle: begin
            uart_tx_d = 1'b1;
            if (tx_en_q && (!tx_en_prev_q || sw_s != tx_last_q)) begin
               tx_state_d = StStart;
               tx_data_d  = {4'b0000, sw_s};
               tx_last_d  = sw_s;
               tx_baud_d  = '0;
               uart_tx_d  = 1'b0;
            end
         end
         StStart: begin
            if (tx_bit_end) begin
               tx_state_d = StData;
               tx_bit_d   = 3'd0;
               uart_tx_d  = tx_data_q[0];
            end
         end
         StData: begin
            if (tx_bit_end) begin
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = StStop;
                  uart_tx_d  = 1'b1;
               end else begin
                  tx_bit_d  = tx_bit_q + 3'd1;
                  uart_tx_d = tx_data_q[tx_bit_q + 3'd1];
               end
            end
         end
         StStop: begin
            if (tx_bit_end) tx_state_d = StIdle;
         end
         default: tx_state_d = StIdle;
      endcase
      if (!tx_en_q) begin
         tx_state_d = StIdle;
         uart_tx_d  = 1'b1;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_data_d  = rx_data_q;
      led_d      = led_q;
      rx_bit_end = (rx_baud_q == BaudLast);
      if (rx_state_q != StIdle) rx_baud_d = rx_bit_end ? '0 : rx_baud_q + 1'b1;
      unique case (rx_state_q)
         StIdle: begin
            if (rx_prev_q && !rx_s) begin
               rx_state_d = StStart;
               rx_baud_d  = '0;
            end
         end
         StStart: begin
            // Mid start bit: a high line here was only a glitch
            if (rx_baud_q == BaudHalf) begin
               rx_state_d = rx_s ? StIdle : StData;
               rx_baud_d  = '0;
               rx_bit_d   = 3'd0;
            end
         end
         StData: begin
            if (rx_bit_end) begin
               rx_data_d = {rx_s, rx_data_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = StStop;
               else rx_bit_d = rx_bit_q + 3'd1;
            end
         end
         StStop: begin
            if (rx_bit_end) begin
               if (rx_s) led_d = rx_data_q[3:0];
               rx_state_d = StIdle;
            end
         end
         default: rx_state_d = StIdle;
      endcase
      if (!rx_en_q) rx_state_d = StIdle;
   end

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         sync_q       <= {SYNC_STAGES{SyncIdle}};
         tx_en_q      <= 1'b0;
         tx_en_prev_q <= 1'b0;
         rx_en_q      <= 1'b0;
         rx_prev_q    <= 1'b1;
         tx_rg_q      <= 2'b10;
         rx_rg_q      <= 2'b10;
         tx_state_q   <= StIdle;
         tx_baud_q    <= '0;
         tx_bit_q     <= '0;
         tx_data_q    <= '0;
         tx_last_q    <= '0;
         uart_tx_q    <= 1'b1;
         rx_state_q   <= StIdle;
         rx_baud_q    <= '0;
         rx_bit_q     <= '0;
         rx_data_q    <= '0;
         led_q        <= '0;
      end else begin
         sync_q[0] <= {btn, sw, uart_rx};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         tx_en_q      <= btn_s[0];
         tx_en_prev_q <= tx_en_q;
         rx_en_q      <= btn_s[1];
         rx_prev_q    <= rx_s;
         // LEDs follow the synchronized buttons directly to keep the latency short
         tx_rg_q      <= {~btn_s[0], btn_s[0]};
         rx_rg_q      <= {~btn_s[1], btn_s[1]};
         tx_state_q   <= tx_state_d;
         tx_baud_q    <= tx_baud_d;
         tx_bit_q     <= tx_bit_d;
         tx_data_q    <= tx_data_d;
         tx_last_q    <= tx_last_d;
         uart_tx_q    <= uart_tx_d;
         rx_state_q   <= rx_state_d;
         rx_baud_q    <= rx_baud_d;
         rx_bit_q     <= rx_bit_d;
         rx_data_q    <= rx_data_d;
         led_q        <= led_d;
      end
   end

   assign uart_tx = uart_tx_q;
   assign led     = led_q;
   assign led5_r  = tx_rg_q[1];
   assign led5_g  = tx_rg_q[0];
   assign led5_b  = 1'b0;
   assign led6_r  = rx_rg_q[1];
   assign led6_g  = rx_rg_q[0];
   assign led6_b  = 1'b0;

endmodule

// File: tb/tb_uart_top.sv
// Directed-plus-random bench for uart_top: status LEDs, TX framing and abort, RX bytes,
// framing errors, glitches and loopback, against a frame-level reference model.
module tb_uart_top;
   localparam int unsigned Clks = 32;
   localparam int unsigned Sync = 2;

   logic       sysclk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] btn = 2'b00;
   logic [3:0] sw = 4'h0;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       rx_line;
   logic       uart_tx;
   logic [3:0] led;
   logic       led5_r, led5_g, led5_b, led6_r, led6_g, led6_b;

   int n_pass = 0;
   int n_total = 0;
   logic [3:0] exp_led = 4'h0;

   assign rx_line = loop_en ? uart_tx : rx_drv;

   always #4 sysclk = ~sysclk;

   uart_top #(.CLKS_PER_BIT(Clks), .SYNC_STAGES(Sync)) dut (
      .sysclk (sysclk),
      .rst_n  (rst_n),
      .btn    (btn),
      .sw     (sw),
      .uart_rx(rx_line),
      .uart_tx(uart_tx),
      .led    (led),
      .led5_r (led5_r),
      .led5_g (led5_g),
      .led5_b (led5_b),
      .led6_r (led6_r),
      .led6_g (led6_g),
      .led6_b (led6_b)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Press buttons 1 ns before an edge and look 2.5 cycles later
   task automatic press(input logic [1:0] b, input logic [2:0] exp5, input logic [2:0] exp6,
                        input string tag);
      #6;
      btn = b;
      #20;
      check({tag, "_led5"}, {led5_r, led5_g, led5_b}, exp5);
      check({tag, "_led6"}, {led6_r, led6_g, led6_b}, exp6);
      tick(1);
   endtask

   task automatic wait_tx_start(input string tag);
      for (int i = 0; i < 12 * Clks && uart_tx !== 1'b0; i++) tick(1);
      check({tag, "_start_seen"}, uart_tx, 1'b0);
   endtask

   // Expected frame is built from the nibble alone: start 0, {0000,nib} LSB first, stop 1
   task automatic check_frame(input logic [3:0] nib, input string tag);
      logic [9:0] f;
      f = {1'b1, 4'b0000, nib, 1'b0};
      wait_tx_start(tag);
      for (int b = 0; b < 10; b++) begin
         check($sformatf("%s_bit%0d_first", tag, b), uart_tx, f[b]);
         tick(Clks - 1);
         check($sformatf("%s_bit%0d_last", tag, b), uart_tx, f[b]);
         tick(1);
      end
      check({tag, "_idle_after"}, uart_tx, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] data, input logic stop);
      rx_drv = 1'b0;
      tick(Clks);
      for (int i = 0; i < 8; i++) begin
         rx_drv = data[i];
         tick(Clks);
      end
      rx_drv = stop;
      tick(Clks);
      rx_drv = 1'b1;
      tick(6);
   endtask

   task automatic wait_led(input logic [3:0] exp, input string tag);
      for (int i = 0; i < 11 * Clks + 10 && led !== exp; i++) tick(1);
      check(tag, led, exp);
   endtask

   initial begin
      logic [7:0] b;
      logic       st;
      logic [3:0] v;
      logic [3:0] prev;

      // Power-up values without any reset, then a one-cycle reset
      tick(2);
      check("pwrup_led5", {led5_r, led5_g, led5_b}, 3'b100);
      check("pwrup_led6", {led6_r, led6_g, led6_b}, 3'b100);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("rst_led5", {led5_r, led5_g, led5_b}, 3'b100);
      check("rst_led6", {led6_r, led6_g, led6_b}, 3'b100);
      check("rst_tx", uart_tx, 1'b1);
      check("rst_led", led, 4'h0);
      tick(2);

      // Enable buttons
      press(2'b10, 3'b100, 3'b010, "rx_en");
      press(2'b01, 3'b010, 3'b100, "tx_en");
      press(2'b11, 3'b010, 3'b010, "both_en");
      // Releasing TX aborts the 0x00 frame started by the enable edge
      btn = 2'b00;
      tick(Sync + 4);
      check("abort_first", uart_tx, 1'b1);
      tick(2 * Clks);

      // TX frame of 1010
      sw  = 4'b1010;
      btn = 2'b01;
      check_frame(4'b1010, "tx_a");
      // New switch value starts a new frame; drop the button during its start bit
      sw = 4'b0101;
      wait_tx_start("tx_b");
      tick(2);
      btn = 2'b00;
      tick(Sync + 2);
      check("tx_abort", uart_tx, 1'b1);
      tick(2 * Clks);
      check("tx_abort_hold", uart_tx, 1'b1);

      // RX: good byte, framing error, glitch
      btn = 2'b10;
      tick(Sync + 3);
      send_byte(8'h5A, 1'b1);
      exp_led = 4'hA;
      check("rx_5a", led, exp_led);
      send_byte(8'h37, 1'b0);
      check("rx_frame_err", led, exp_led);
      tick(2 * Clks);
      rx_drv = 1'b0;
      tick(10);
      rx_drv = 1'b1;
      tick(3 * Clks);
      check("rx_glitch", led, exp_led);
      for (int k = 0; k < 6; k++) begin
         b  = 8'($urandom_range(0, 255));
         st = ($urandom_range(0, 3) != 0);
         send_byte(b, st);
         if (st) exp_led = b[3:0];
         check($sformatf("rx_rand%0d", k), led, exp_led);
      end
      // Receiver disabled: led holds
      btn = 2'b00;
      tick(Sync + 3);
      b = exp_led == 4'h3 ? 8'hC4 : 8'h93;
      send_byte(b, 1'b1);
      check("rx_disabled", led, exp_led);
      btn = 2'b10;
      tick(Sync + 3);
      send_byte(8'h00, 1'b1);
      exp_led = 4'h0;
      check("rx_zero", led, exp_led);

      // Loopback
      loop_en = 1'b1;
      sw  = 4'b0110;
      btn = 2'b11;
      wait_led(4'b0110, "loop_0110");
      sw = 4'b1111;
      wait_led(4'b1111, "loop_1111");
      prev = 4'b1111;
      for (int k = 0; k < 3; k++) begin
         v = 4'($urandom_range(0, 15));
         if (v == prev) v = v ^ 4'h1;
         sw = v;
         wait_led(v, $sformatf("loop_rand%0d", k));
         prev = v;
      end

      // Reset in the middle of a frame
      sw = prev ^ 4'h8;
      tick(3 * Clks);
      rst_n = 1'b0;
      tick(1);
      check("midrst_tx", uart_tx, 1'b1);
      check("midrst_led", led, 4'h0);
      check("midrst_led5", {led5_r, led5_g, led5_b}, 3'b100);
      check("midrst_led6", {led6_r, led6_g, led6_b}, 3'b100);
      rst_n = 1'b1;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
